// File: rtl/cdr_loop_ctrl.sv
// cdr_loop_ctrl: digital CDR loop controller.
// Early/late votes from the bang-bang phase detector are summed over a fixed window.
// Each closed window yields a direction that drives a proportional + integral loop.
// The loop positions the phase-interpolator code. An IDLE/ACQ/TRACK/HOLD machine
// handles lock detection, slip recovery and the freeze (hold) mode.
module cdr_loop_ctrl #(
    parameter int PW           = 6,
    parameter int FRAC         = 4,
    parameter int WIN_LOG2     = 4,
    parameter int THRESH       = 2,
    parameter int KP_ACQ       = 8,
    parameter int KP_TRK       = 2,
    parameter int KI           = 1,
    parameter int FREQ_MAX     = 8,
    parameter int LOCK_TH      = 2,
    parameter int LOCK_WINDOWS = 8,
    parameter int UNLOCK_TH    = 12
) (
    input  logic          dclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          freeze,
    input  logic          e,
    input  logic          l,
    output logic [PW-1:0] pi_code,
    output logic          pi_upd,
    output logic          locked,
    output logic [1:0]    state
);
    localparam int AW = PW + FRAC;                   // phase accumulator width
    localparam int VW = WIN_LOG2 + 2;                // signed vote sum width
    localparam int FW = $clog2(FREQ_MAX + 1) + 1;    // signed integral width
    localparam int SW = AW + 4;                      // signed width for loop arithmetic
    localparam int CW = $clog2(LOCK_WINDOWS + 1);    // quiet-window counter width

    localparam logic signed [VW-1:0] P_THRESH = VW'(THRESH);
    localparam logic signed [VW-1:0] P_LOCK   = VW'(LOCK_TH);
    localparam logic signed [VW-1:0] P_SLIP   = VW'(UNLOCK_TH);
    localparam logic signed [SW-1:0] P_FMAX   = SW'(FREQ_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    state_t                r_saved, w_saved_nxt;    // state to resume after HOLD
    logic signed [VW-1:0]  r_vote_sum;
    logic [WIN_LOG2-1:0]   r_win_cnt;
    logic [CW-1:0]         r_lock_cnt;
    logic [1:0]            r_slip_cnt;
    logic                  r_upd_pend;              // a window closed last cycle
    logic signed [1:0]     r_dir;
    logic                  r_kp_trk;                // closed window was in TRACK
    logic signed [FW-1:0]  r_freq_acc;
    logic [AW-1:0]         r_phase_acc;
    logic                  r_pi_upd;

    logic signed [VW-1:0]  w_vote, w_sum;
    logic signed [1:0]     w_dir;
    logic                  w_run, w_win_end, w_close;
    logic                  w_quiet, w_slip, w_lock_done, w_slip_done;
    logic signed [SW-1:0]  w_freq_raw, w_freq_sat, w_kp, w_step;
    logic [AW-1:0]         w_phase_nxt;

    // Window arithmetic: this cycle's vote, the total including it, and its classification
    always_comb begin
        // NOTE: every combinational output is given a default first so no path infers a latch.
        w_vote = '0;
        if (e && !l)      w_vote = VW'(1);
        else if (l && !e) w_vote = '1;              // -1
        w_sum       = r_vote_sum + w_vote;
        w_run       = enable && !freeze && (r_state == S_ACQ || r_state == S_TRACK);
        w_win_end   = (r_win_cnt == '1);
        w_close     = w_run && w_win_end;
        w_dir       = 2'b00;
        if (w_sum > P_THRESH)       w_dir = 2'b01;
        else if (w_sum < -P_THRESH) w_dir = 2'b11;
        w_quiet     = (w_sum <= P_LOCK) && (w_sum >= -P_LOCK);
        w_slip      = (w_sum >= P_SLIP) || (w_sum <= -P_SLIP);
        w_lock_done = w_quiet && (r_lock_cnt == CW'(LOCK_WINDOWS - 1));
        w_slip_done = w_slip && (r_slip_cnt == 2'd1);
    end

    // State register
    always_ff @(posedge dclk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_saved <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_saved <= w_saved_nxt;
        end
    end

    // Next-state: disable beats freeze, freeze beats window close
    always_comb begin
        w_state_nxt = r_state;
        w_saved_nxt = r_saved;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ACQ;
                S_ACQ, S_TRACK: begin
                    if (freeze) begin
                        w_state_nxt = S_HOLD;
                        w_saved_nxt = r_state;
                    end else if (w_win_end) begin
                        if (r_state == S_ACQ && w_lock_done)   w_state_nxt = S_TRACK;
                        if (r_state == S_TRACK && w_slip_done) w_state_nxt = S_ACQ;
                    end
                end
                S_HOLD: if (!freeze) w_state_nxt = r_saved;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs: locked follows TRACK and keeps its value through a HOLD taken from TRACK
    always_comb begin
        locked = (r_state == S_TRACK) || (r_state == S_HOLD && r_saved == S_TRACK);
    end

    assign state   = r_state;
    assign pi_code = r_phase_acc[AW-1:FRAC];
    assign pi_upd  = r_pi_upd;

    // Vote window and lock/slip counters; any non-running cycle discards the partial window
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote_sum <= '0;
            r_win_cnt  <= '0;
            r_lock_cnt <= '0;
            r_slip_cnt <= '0;
        end else if (!enable) begin
            r_vote_sum <= '0;
            r_win_cnt  <= '0;
            r_lock_cnt <= '0;
            r_slip_cnt <= '0;
        end else if (!w_run) begin
            r_vote_sum <= '0;
            r_win_cnt  <= '0;
        end else if (w_win_end) begin
            r_vote_sum <= '0;
            r_win_cnt  <= '0;
            if (r_state == S_ACQ) begin
                if (!w_quiet || w_lock_done) r_lock_cnt <= '0;
                else                         r_lock_cnt <= r_lock_cnt + CW'(1);
            end else begin
                if (!w_slip) begin
                    r_slip_cnt <= '0;
                end else if (w_slip_done) begin
                    r_slip_cnt <= '0;
                    r_lock_cnt <= '0;
                end else begin
                    r_slip_cnt <= r_slip_cnt + 2'd1;
                end
            end
        end else begin
            r_vote_sum <= w_sum;
            r_win_cnt  <= r_win_cnt + WIN_LOG2'(1);
        end
    end

    // Capture the window decision; the gain is chosen by the state the window closed in
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_pend <= 1'b0;
            r_dir      <= '0;
            r_kp_trk   <= 1'b0;
        end else begin
            r_upd_pend <= w_close;
            if (w_close) begin
                r_dir    <= w_dir;
                r_kp_trk <= (r_state == S_TRACK);
            end
        end
    end

    // Loop filter arithmetic: saturating integral path plus proportional kick
    always_comb begin
        w_freq_raw = SW'(r_freq_acc) + SW'(r_dir) * SW'(KI);
        w_freq_sat = w_freq_raw;
        if (w_freq_raw > P_FMAX)       w_freq_sat = P_FMAX;
        else if (w_freq_raw < -P_FMAX) w_freq_sat = -P_FMAX;
        w_kp        = r_kp_trk ? SW'(KP_TRK) : SW'(KP_ACQ);
        w_step      = SW'(r_dir) * w_kp + w_freq_sat;
        w_phase_nxt = r_phase_acc + AW'(w_step);    // modular wrap of the phase
    end

    // Apply the pending loop update one cycle after window close and flag code changes
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq_acc  <= '0;
            r_phase_acc <= '0;
            r_pi_upd    <= 1'b0;
        end else if (r_upd_pend) begin
            r_freq_acc  <= FW'(w_freq_sat);
            r_phase_acc <= w_phase_nxt;
            r_pi_upd    <= (w_phase_nxt[AW-1:FRAC] != r_phase_acc[AW-1:FRAC]);
        end else begin
            r_pi_upd    <= 1'b0;
        end
    end

endmodule
